// File: rtl/hpi_bus_sequencer.sv
// hpi_bus_sequencer
//
// Shares the CY7C67200 HPI bus between two requesters and turns each granted
// access into a timed chip-select/strobe cycle: SETUP -> STROBE -> HOLD.
// Requester 0 is the NIOS PIO path, requester 1 the hardware keycode poller.
// Ties are broken round-robin against the last granted requester.
//
// Handshake: reqN is a level that the requester holds until ackN. ackN is a
// single-cycle pulse in the last HOLD cycle. The requester drops reqN in the
// cycle after ackN; a reqN still high at the next IDLE edge is a new request.
// Dropping reqN mid-transaction does not cancel the access.
//
// Optional feature: define HPI_RST_SEQ_EN to generate a RST_CYC-cycle
// power-up reset pulse on hpi_rst_n after Reset is released. Requests are
// held off and busy stays high for the duration of that pulse. Without the
// macro, hpi_rst_n is simply ~Reset.
//
// Ports:
//   Clk, Reset                 clock, asynchronous active-high reset
//   req0/we0/addr0/wdata0      requester 0 request, direction, address, data
//   ack0                       requester 0 completion pulse
//   req1/we1/addr1/wdata1      requester 1 request, direction, address, data
//   ack1                       requester 1 completion pulse
//   rdata                      last captured read data (shared)
//   hpi_addr/hpi_dout/hpi_oe   address, write data and data-drive enable to pads
//   hpi_din                    OTG_DATA sampled from the pad
//   hpi_cs_n/hpi_rd_n/hpi_wr_n active-low bus strobes
//   hpi_rst_n                  active-low CY7C67200 reset
//   busy                       high whenever the sequencer is not idle
//   dbg_state                  current FSM state (0 IDLE, 1 SETUP, 2 STROBE, 3 HOLD)

module hpi_bus_sequencer #(
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 2,
    parameter int RST_CYC    = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req0,
    input  logic        we0,
    input  logic [1:0]  addr0,
    input  logic [15:0] wdata0,
    output logic        ack0,
    input  logic        req1,
    input  logic        we1,
    input  logic [1:0]  addr1,
    input  logic [15:0] wdata1,
    output logic        ack1,
    output logic [15:0] rdata,
    output logic [1:0]  hpi_addr,
    output logic [15:0] hpi_dout,
    output logic        hpi_oe,
    input  logic [15:0] hpi_din,
    output logic        hpi_cs_n,
    output logic        hpi_rd_n,
    output logic        hpi_wr_n,
    output logic        hpi_rst_n,
    output logic        busy,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } state_t;

    // Phase counters count down to zero, so each load is length-1.
    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        gnt_q, gnt_d;            // requester owning the current access
    logic        last_grant_q, last_grant_d;
    logic        we_q, we_d;
    logic [1:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;

    logic        rst_done;                // high once requests may be accepted
    logic        pick;                    // requester that would win this cycle

    // ------------------------------------------------------------------
    // HPI reset pulse
    // ------------------------------------------------------------------
`ifdef HPI_RST_SEQ_EN
    localparam int RCW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);

    logic [RCW-1:0] rst_cnt_q, rst_cnt_d;
    logic           rst_done_q, rst_done_d;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rst_cnt_q  <= '0;
            rst_done_q <= 1'b0;
        end else begin
            rst_cnt_q  <= rst_cnt_d;
            rst_done_q <= rst_done_d;
        end
    end

    always_comb begin
        rst_cnt_d  = rst_cnt_q;
        rst_done_d = rst_done_q;
        if (!rst_done_q) begin
            if (rst_cnt_q == RST_LAST) begin
                rst_done_d = 1'b1;
            end else begin
                rst_cnt_d = rst_cnt_q + 1'b1;
            end
        end
    end

    assign rst_done  = rst_done_q;
    assign hpi_rst_n = rst_done_q;
`else
    // No power-up pulse: the chip reset simply follows the system reset and
    // requests are accepted immediately (RST_CYC plays no part here).
    assign rst_done  = (RST_CYC >= 0);
    assign hpi_rst_n = ~Reset;
`endif

    // ------------------------------------------------------------------
    // Arbitration: a lone requester wins; on a tie the one that was not
    // granted last time wins.
    // ------------------------------------------------------------------
    assign pick = (req0 && req1) ? ~last_grant_q : req1;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 4'd0;
            gnt_q        <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= 2'd0;
            wdata_q      <= 16'h0000;
            rdata_q      <= 16'h0000;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            gnt_q        <= gnt_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rdata_q      <= rdata_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        gnt_d        = gnt_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;

        case (state_q)
            ST_IDLE: begin
                if ((req0 || req1) && rst_done) begin
                    gnt_d        = pick;
                    last_grant_d = pick;
                    we_d         = pick ? we1    : we0;
                    addr_d       = pick ? addr1  : addr0;
                    wdata_d      = pick ? wdata1 : wdata0;
                    cnt_d        = SETUP_LD;
                    state_d      = ST_SETUP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 4'd0) begin
                    cnt_d   = STROBE_LD;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_STROBE: begin
                if (cnt_q == 4'd0) begin
                    // Sample the pad on the edge that ends the read strobe.
                    if (!we_q) begin
                        rdata_d = hpi_din;
                    end
                    cnt_d   = HOLD_LD;
                    state_d = ST_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_HOLD: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from the registered state so that an asynchronous
    // Reset releases every strobe and suppresses any ack immediately.
    // ------------------------------------------------------------------
    always_comb begin
        hpi_cs_n = 1'b1;
        hpi_rd_n = 1'b1;
        hpi_wr_n = 1'b1;
        hpi_oe   = 1'b0;
        ack0     = 1'b0;
        ack1     = 1'b0;

        case (state_q)
            ST_SETUP: begin
                hpi_cs_n = 1'b0;
                hpi_oe   = we_q;
            end
            ST_STROBE: begin
                hpi_cs_n = 1'b0;
                hpi_oe   = we_q;
                hpi_rd_n = we_q;
                hpi_wr_n = ~we_q;
            end
            ST_HOLD: begin
                hpi_cs_n = 1'b0;
                hpi_oe   = we_q;
                if (cnt_q == 4'd0) begin
                    ack0 = ~gnt_q;
                    ack1 = gnt_q;
                end
            end
            default: begin
                hpi_cs_n = 1'b1;
            end
        endcase
    end

    assign hpi_addr  = addr_q;
    assign hpi_dout  = wdata_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != ST_IDLE) || !rst_done;
    assign dbg_state = state_q;

endmodule

// File: doc/hpi_bus_sequencer.md
Name: hpi_bus_sequencer

Overview:
- Hardware sequencer and two-port arbiter for the CY7C67200 HPI bus.
- Shares the HPI between requester 0 (NIOS software PIO path) and requester 1 (hardware keycode poller), granted round-robin.
- Each granted access is expanded into a timed chip-select/strobe cycle: SETUP, STROBE, HOLD.
- Outputs feed the existing tri-state OTG pad interface.

Parameters:
- SETUP_CYC, 2, Clk cycles CS_N/address are asserted before the strobe; legal range 1..15.
- STROBE_CYC, 4, Clk cycles RD_N or WR_N is held low; legal range 1..15.
- HOLD_CYC, 2, Clk cycles CS_N/address/data are held after the strobe rises; legal range 1..15.
- RST_CYC, 16, Clk cycles of the power-up HPI reset pulse; only used with HPI_RST_SEQ_EN.

Ports:
- Clk  in  1  system clock, 50 MHz
- Reset  in  1  asynchronous, active-high reset
- req0  in  1  requester 0 access request; level, held until ack0
- we0  in  1  requester 0: 1 = write, 0 = read
- addr0  in  2  requester 0 HPI address
- wdata0  in  16  requester 0 write data
- ack0  out  1  requester 0 completion pulse, 1 cycle
- req1, we1, addr1, wdata1, ack1  same as requester 0, for requester 1
- rdata  out  16  last captured read data, shared by both requesters
- hpi_addr  out  2  to OTG_ADDR
- hpi_dout  out  16  write data to pad
- hpi_oe  out  1  1 = drive OTG_DATA
- hpi_din  in  16  OTG_DATA as sampled from the pad
- hpi_cs_n, hpi_rd_n, hpi_wr_n  out  1 each  active-low strobes
- hpi_rst_n  out  1  active-low CY7C67200 reset
- busy  out  1  1 whenever state != IDLE

Behaviour:
- Reset values:
  - cs_n, rd_n and wr_n are 1; hpi_oe=0; hpi_addr=0; hpi_dout=0; rdata=0.
  - ack0=ack1=0; busy=0; state=IDLE; last_grant=1, so requester 0 wins the first tie.
- Reset asserted mid-transaction: all strobes deassert asynchronously, no ack is issued, and the transaction is abandoned.
- States are IDLE, SETUP, STROBE, HOLD. A 4-bit down-counter cnt times each phase.
- IDLE:
  - If any req is high at a rising edge, grant one requester and latch its we/addr/wdata.
  - Load cnt=SETUP_CYC-1 and go to SETUP.
  - Arbitration:
    - Only one requester high: grant it.
    - Both high: grant the one that was not last_grant.
    - Update last_grant on every grant.
- SETUP:
  - cs_n=0, hpi_addr=latched address, hpi_oe=latched we, hpi_dout=latched wdata.
  - When cnt=0: load STROBE_CYC-1 and go to STROBE; otherwise decrement.
- STROBE:
  - rd_n=0 for a read, or wr_n=0 for a write; cs_n, addr and oe are unchanged.
  - When cnt=0:
    - Read: rdata<=hpi_din on this edge.
    - Load HOLD_CYC-1 and go to HOLD.
- HOLD:
  - rd_n=wr_n=1; cs_n, addr, oe and dout are held.
  - When cnt=0: ackN=1 for this single cycle for the granted requester, then go to IDLE. At the IDLE entry cs_n=1 and oe=0.
- Latency, with request sampled at edge 0 and defaults:
  - SETUP in cycles 1-2, STROBE in cycles 3-6, HOLD in cycles 7-8.
  - ack in cycle 8; rdata valid from cycle 7.
  - General case: ack arrives SETUP_CYC+STROBE_CYC+HOLD_CYC cycles after grant.
- Minimum gap between transactions is one IDLE cycle with cs_n=1. cs_n never stays low across two transactions.
- Requester obligations:
  - Drop req in the cycle after ack.
  - A req still high one cycle after ack is treated as a new request.
- req dropped mid-transaction: the transaction still completes and ack still pulses.
- rdata holds its value until the next read capture; writes never modify it.
- hpi_rd_n and hpi_wr_n are never low simultaneously.

Optional Feature:
- Macro: HPI_RST_SEQ_EN.
- Defined:
  - After Reset deasserts, hpi_rst_n stays 0 for RST_CYC cycles, then goes to 1.
  - IDLE ignores all requests until hpi_rst_n=1, and busy=1 during this pulse.
- Not defined: hpi_rst_n=~Reset combinationally, and requests are accepted on the first cycle after reset.

Test Plan:
- Single read: req0=1, we0=0, addr0=2, hpi_din=16'hBEEF.
  - cs_n low in cycles 1-8; rd_n low in cycles 3-6; wr_n stays 1.
  - ack0 in cycle 8; rdata=16'hBEEF from cycle 7.
- Single write: req1=1, we1=1, addr1=1, wdata1=16'h1234.
  - hpi_oe=1 and hpi_dout=16'h1234 in cycles 1-8; wr_n low in cycles 3-6.
  - ack1 in cycle 8; rdata unchanged.
- Simultaneous requests: req0=req1=1 held continuously after reset.
  - Grants alternate 0,1,0,1; each ack is 8 cycles after its grant.
  - cs_n=1 for exactly one cycle between transactions.
- Reset mid-strobe: assert Reset in cycle 4 of a write.
  - wr_n and cs_n go to 1 asynchronously and no ack is issued.
  - After release, a new req0 completes normally.
- Parameters SETUP_CYC=1, STROBE_CYC=1, HOLD_CYC=1: ack arrives 3 cycles after grant and rd_n is low for exactly 1 cycle.
- HPI_RST_SEQ_EN with RST_CYC=16: hpi_rst_n=0 for 16 cycles after Reset release, a req0 during that window is held off, and it is granted on the first cycle with hpi_rst_n=1.
